// File: rtl/udp_tx_arbiter_pkg.sv
// udp_tx_arbiter shared definitions.
// State encoding and protocol constants.
package udp_tx_arbiter_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CHECK = 3'd1,
    ST_START = 3'd2,
    ST_BUSY  = 3'd3,
    ST_GAP   = 3'd4
  } arb_state_t;

  localparam int UDP_MAX_PAYLOAD = 1472;
  localparam int ETH_IFG_BYTES   = 12;

endpackage

// File: rtl/udp_tx_arbiter_rr_pick.sv
// Round-robin priority encoder.
// Picks the first set req bit at or above ptr, with wrap.
module rr_pick #(
  parameter int N_CH = 4,
  parameter int IW   = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic [N_CH-1:0] req,
  input  logic [IW-1:0]   ptr,
  output logic [IW-1:0]   idx,
  output logic            found
);

  logic [N_CH-1:0] rot;
  logic [IW:0]     sum;

  always_comb begin
    rot   = N_CH'({req, req} >> ptr);
    found = 1'b0;
    sum   = '0;
    // Descending scan so the lowest rotated index wins.
    for (int k = N_CH - 1; k >= 0; k--) begin
      if (rot[k]) begin
        found = 1'b1;
        sum   = {1'b0, ptr} + (IW+1)'(k);
      end
    end
    if (sum >= (IW+1)'(N_CH))
      sum = sum - (IW+1)'(N_CH);
    idx = sum[IW-1:0];
  end

endmodule

// File: rtl/udp_tx_arbiter.sv
// Round-robin sharing of one UDP frame generator
// between N_CH payload sources, with IFG and watchdog.
module udp_tx_arbiter
  import udp_tx_arbiter_pkg::*;
#(
  parameter int N_CH       = 4,
  parameter int LEN_W      = 16,
  parameter int MAX_LEN    = UDP_MAX_PAYLOAD,
  parameter int IFG_CYCLES = ETH_IFG_BYTES,
  parameter int TIMEOUT    = 4096
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [N_CH-1:0]   ch_req,
  input  logic [N_CH*LEN_W-1:0] ch_len,
  input  logic [N_CH*16-1:0] ch_port,
  input  logic [N_CH*8-1:0] ch_data,
  output logic [N_CH-1:0]   ch_rd,
  output logic [N_CH-1:0]   ch_ack,
  output logic [N_CH-1:0]   ch_err,
  output logic              gen_start,
  output logic [LEN_W-1:0]  gen_len,
  output logic [15:0]       gen_port,
  input  logic              gen_rd,
  output logic [7:0]        gen_data,
  input  logic              gen_done,
  output logic              busy,
  output logic [2:0]        cur_ch
);

  localparam int IW = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int WW = $clog2(TIMEOUT) + 1;
  localparam int GW = $clog2(IFG_CYCLES) + 1;

  arb_state_t       state_q, state_d;
  logic [IW-1:0]    rr_q, rr_d;
  logic [IW-1:0]    cur_q, cur_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [15:0]      port_q, port_d;
  logic [WW-1:0]    wd_q, wd_d;
  logic [GW-1:0]    gap_q, gap_d;
  logic [IW-1:0]    pick_idx;
  logic             pick_found;
  logic [IW-1:0]    nxt_ch;

  logic [LEN_W-1:0] len_arr  [N_CH];
  logic [15:0]      port_arr [N_CH];
  logic [7:0]       data_arr [N_CH];

  for (genvar i = 0; i < N_CH; i++) begin : g_unpack
    assign len_arr[i]  = ch_len[i*LEN_W +: LEN_W];
    assign port_arr[i] = ch_port[i*16 +: 16];
    assign data_arr[i] = ch_data[i*8 +: 8];
  end

  rr_pick #(
    .N_CH (N_CH),
    .IW   (IW)
  ) u_pick (
    .req   (ch_req),
    .ptr   (rr_q),
    .idx   (pick_idx),
    .found (pick_found)
  );

  assign nxt_ch = (cur_q == IW'(N_CH - 1)) ?
                  '0 : cur_q + 1'b1;

  always_comb begin
    state_d   = state_q;
    rr_d      = rr_q;
    cur_d     = cur_q;
    len_d     = len_q;
    port_d    = port_q;
    wd_d      = wd_q;
    gap_d     = gap_q;
    gen_start = 1'b0;
    ch_rd     = '0;
    ch_ack    = '0;
    ch_err    = '0;
    unique case (state_q)
      ST_IDLE: begin
        if (pick_found) begin
          cur_d   = pick_idx;
          len_d   = len_arr[pick_idx];
          port_d  = port_arr[pick_idx];
          state_d = ST_CHECK;
        end
      end
      ST_CHECK: begin
        if (len_q == '0 ||
            len_q > LEN_W'(MAX_LEN)) begin
          ch_err[cur_q] = 1'b1;
          rr_d          = nxt_ch;
          state_d       = ST_IDLE;
        end else begin
          state_d = ST_START;
        end
      end
      ST_START: begin
        gen_start = 1'b1;
        wd_d      = '0;
        state_d   = ST_BUSY;
      end
      ST_BUSY: begin
        ch_rd[cur_q] = gen_rd;
        // Completion beats a simultaneous timeout.
        if (gen_done) begin
          ch_ack[cur_q] = 1'b1;
          rr_d          = nxt_ch;
          gap_d         = GW'(IFG_CYCLES - 1);
          state_d       = ST_GAP;
        end else if (wd_q == WW'(TIMEOUT - 1)) begin
          ch_err[cur_q] = 1'b1;
          rr_d          = nxt_ch;
          gap_d         = GW'(IFG_CYCLES - 1);
          state_d       = ST_GAP;
        end else begin
          wd_d = wd_q + 1'b1;
        end
      end
      ST_GAP: begin
        if (gap_q == '0)
          state_d = ST_IDLE;
        else
          gap_d = gap_q - 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      rr_q    <= '0;
      cur_q   <= '0;
      len_q   <= '0;
      port_q  <= '0;
      wd_q    <= '0;
      gap_q   <= '0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      cur_q   <= cur_d;
      len_q   <= len_d;
      port_q  <= port_d;
      wd_q    <= wd_d;
      gap_q   <= gap_d;
    end
  end

  assign gen_len  = len_q;
  assign gen_port = port_q;
  assign gen_data = data_arr[cur_q];
  assign busy     = (state_q != ST_IDLE);
  assign cur_ch   = 3'(cur_q);

endmodule

// File: tb/tb_udp_tx_arbiter.sv
// Scoreboard bench for udp_tx_arbiter.
// Expected grants/acks/errs are queued by stimulus, popped by a monitor.
module tb_udp_tx_arbiter;

  localparam int N  = 4;
  localparam int LW = 16;

  logic clk = 1'b0;
  logic rst_n;
  logic [N-1:0]    ch_req;
  logic [N*LW-1:0] ch_len;
  logic [N*16-1:0] ch_port;
  logic [N*8-1:0]  ch_data;
  logic [N-1:0]    ch_rd, ch_ack, ch_err;
  logic            gen_start;
  logic [LW-1:0]   gen_len;
  logic [15:0]     gen_port;
  logic            gen_rd;
  logic [7:0]      gen_data;
  logic            gen_done;
  logic            busy;
  logic [2:0]      cur_ch;

  always #5 clk = ~clk;

  udp_tx_arbiter #(
    .N_CH       (N),
    .LEN_W      (LW),
    .MAX_LEN    (1472),
    .IFG_CYCLES (12),
    .TIMEOUT    (4096)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ch_req    (ch_req),
    .ch_len    (ch_len),
    .ch_port   (ch_port),
    .ch_data   (ch_data),
    .ch_rd     (ch_rd),
    .ch_ack    (ch_ack),
    .ch_err    (ch_err),
    .gen_start (gen_start),
    .gen_len   (gen_len),
    .gen_port  (gen_port),
    .gen_rd    (gen_rd),
    .gen_data  (gen_data),
    .gen_done  (gen_done),
    .busy      (busy),
    .cur_ch    (cur_ch)
  );

  typedef struct {int ch; int len; int port;} grant_t;
  typedef struct {bit is_err; int ch;} evt_t;

  grant_t exp_grant[$];
  evt_t   exp_evt[$];
  grant_t mg;
  evt_t   me;
  int vectors = 0;
  int miscompares = 0;
  int model_ptr = 0;

  function automatic int pick(logic [N-1:0] req, int ptr);
    for (int k = 0; k < N; k++)
      if (req[(ptr + k) % N]) return (ptr + k) % N;
    return -1;
  endfunction

  task automatic expect_grant(input logic [N-1:0] req,
                              output int w);
    grant_t g;
    w = pick(req, model_ptr);
    g.ch   = w;
    g.len  = int'(ch_len[w*LW +: LW]);
    g.port = int'(ch_port[w*16 +: 16]);
    exp_grant.push_back(g);
  endtask

  task automatic expect_evt(input bit is_err, input int ch);
    evt_t e;
    e.is_err = is_err;
    e.ch     = ch;
    exp_evt.push_back(e);
    model_ptr = (ch + 1) % N;
  endtask

  // Monitor: grants, ack/err pulses, read-strobe routing.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (gen_start) begin
        vectors++;
        if (exp_grant.size() == 0) begin
          miscompares++;
          $display("FAIL unexpected_start cur_ch=%0d", cur_ch);
        end else begin
          mg = exp_grant.pop_front();
          if (cur_ch !== 3'(mg.ch) ||
              gen_len !== LW'(mg.len) ||
              gen_port !== 16'(mg.port)) begin
            miscompares++;
            $display("FAIL grant got ch=%0d len=%0d port=%h exp ch=%0d len=%0d port=%h",
                     cur_ch, gen_len, gen_port, mg.ch, mg.len, mg.port);
          end
        end
      end
      if ((ch_ack | ch_err) != '0) begin
        vectors++;
        if (exp_evt.size() == 0) begin
          miscompares++;
          $display("FAIL unexpected_evt ack=%b err=%b", ch_ack, ch_err);
        end else begin
          me = exp_evt.pop_front();
          if (ch_ack !== (me.is_err ? 4'b0 : 4'b1 << me.ch) ||
              ch_err !== (me.is_err ? 4'b1 << me.ch : 4'b0)) begin
            miscompares++;
            $display("FAIL evt got ack=%b err=%b exp is_err=%0d ch=%0d",
                     ch_ack, ch_err, me.is_err, me.ch);
          end
        end
      end
      if (ch_rd != '0) begin
        vectors++;
        if (!gen_rd || !busy || ch_rd !== (4'b1 << cur_ch)) begin
          miscompares++;
          $display("FAIL rd_route got ch_rd=%b gen_rd=%b cur=%0d",
                   ch_rd, gen_rd, cur_ch);
        end
      end
    end
  end

  task automatic wait_start(input int bound, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!gen_start && n < bound);
    if (!gen_start) begin
      vectors++;
      miscompares++;
      $display("FAIL start_timeout got none exp gen_start");
      n = -1;
    end
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (busy && n < 60);
    if (busy) begin
      vectors++;
      miscompares++;
      $display("FAIL idle_timeout got busy=1 exp 0");
    end
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst_n = 1'b0;
    ch_req = '0; gen_rd = 1'b0; gen_done = 1'b0;
    exp_grant.delete();
    exp_evt.delete();
    model_ptr = 0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    ch_req = '0; ch_len = '0; ch_port = '0; ch_data = '0;
    gen_rd = 1'b1; gen_done = 1'b0;
    repeat (2) @(negedge clk);
    vectors++;
    if (busy !== 1'b0 || gen_start !== 1'b0 || cur_ch !== 3'd0) begin
      miscompares++;
      $display("FAIL reset_ctl got busy=%b start=%b cur=%0d exp 0 0 0",
               busy, gen_start, cur_ch);
    end
    vectors++;
    if (gen_len !== '0 || gen_port !== '0) begin
      miscompares++;
      $display("FAIL reset_latch got len=%0d port=%h exp 0 0", gen_len, gen_port);
    end
    vectors++;
    if ((ch_rd | ch_ack | ch_err) !== '0) begin
      miscompares++;
      $display("FAIL reset_pulses got rd=%b ack=%b err=%b exp 0",
               ch_rd, ch_ack, ch_err);
    end
    gen_rd = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
  endtask

  task automatic test_single();
    int n, w, got;
    logic [7:0] b;
    ch_len[0 +: LW]  = 16'd18;
    ch_port[0 +: 16] = 16'hC360;
    expect_grant(4'b0001, w);
    @(posedge clk); #1 ch_req = 4'b0001;
    wait_start(50, n);
    vectors++;
    if (n !== 3) begin
      miscompares++;
      $display("FAIL start_latency got %0d exp 3", n);
    end
    got = 0;
    for (int i = 0; got < 18 && i < 60; i++) begin
      @(posedge clk); #1;
      gen_rd = (i % 3 != 2);
      b = 8'(i * 7 + 3);
      ch_data[7:0] = b;
      ch_data[15:8] = ~b;
      @(negedge clk);
      vectors++;
      if (ch_rd !== {3'b0, gen_rd} || gen_data !== b) begin
        miscompares++;
        $display("FAIL single_rd got rd=%b data=%h exp rd=%b data=%h",
                 ch_rd, gen_data, {3'b0, gen_rd}, b);
      end
      if (ch_rd[0]) got++;
    end
    vectors++;
    if (got !== 18) begin
      miscompares++;
      $display("FAIL rd_count got %0d exp 18", got);
    end
    @(posedge clk); #1;
    gen_rd = 1'b0; gen_done = 1'b1;
    expect_evt(1'b0, 0);
    @(negedge clk);
    vectors++;
    if (ch_ack !== 4'b0001) begin
      miscompares++;
      $display("FAIL single_ack got %b exp 0001", ch_ack);
    end
    @(posedge clk); #1;
    gen_done = 1'b0; ch_req = '0; gen_rd = 1'b1;
    n = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (busy) begin
        n++;
        vectors++;
        if (ch_rd !== '0) begin
          miscompares++;
          $display("FAIL gap_rd got %b exp 0000", ch_rd);
        end
      end else begin
        i = 40;
      end
    end
    gen_rd = 1'b0;
    vectors++;
    if (n !== 12) begin
      miscompares++;
      $display("FAIL gap_len got %0d exp 12", n);
    end
  endtask

  task automatic test_fairness();
    int n, w;
    do_reset();
    for (int i = 0; i < N; i++) begin
      ch_len[i*LW +: LW]  = LW'(10 + i * 5);
      ch_port[i*16 +: 16] = 16'(16'h1000 + i);
    end
    ch_req = 4'hF;
    for (int r = 0; r < 6; r++) begin
      expect_grant(4'hF, w);
      wait_start(50, n);
      vectors++;
      if (cur_ch !== 3'(r % 4)) begin
        miscompares++;
        $display("FAIL fair_order got %0d exp %0d", cur_ch, r % 4);
      end
      @(posedge clk); #1;
      gen_done = 1'b1; gen_rd = 1'b1;
      expect_evt(1'b0, w);
      @(posedge clk); #1;
      gen_done = 1'b0; gen_rd = 1'b0;
      if (r == 5) ch_req = '0;
    end
    wait_idle();
  endtask

  task automatic test_length();
    int n, w;
    ch_len[2*LW +: LW] = 16'd0;
    ch_len[1*LW +: LW] = 16'd1473;
    ch_len[3*LW +: LW] = 16'd1472;
    for (int t = 0; t < 2; t++) begin
      w = (t == 0) ? 2 : 1;
      expect_evt(1'b1, w);
      @(posedge clk); #1 ch_req = 4'b1 << w;
      n = 0;
      do begin
        @(negedge clk);
        n++;
      end while (ch_err == '0 && n < 20);
      vectors++;
      if (n !== 2 || ch_err !== (4'b1 << w)) begin
        miscompares++;
        $display("FAIL len_reject ch=%0d got err=%b n=%0d exp err=%b n=2",
                 w, ch_err, n, 4'b1 << w);
      end
      @(posedge clk); #1 ch_req = '0;
      repeat (3) @(posedge clk);
    end
    expect_grant(4'b1000, w);
    @(posedge clk); #1 ch_req = 4'b1000;
    wait_start(50, n);
    vectors++;
    if (gen_len !== 16'd1472) begin
      miscompares++;
      $display("FAIL len_max got %0d exp 1472", gen_len);
    end
    @(posedge clk); #1 gen_done = 1'b1;
    expect_evt(1'b0, 3);
    @(posedge clk); #1;
    gen_done = 1'b0; ch_req = '0;
    wait_idle();
  endtask

  task automatic test_watchdog();
    int n, w;
    ch_len[0 +: LW]    = 16'd100;
    ch_len[2*LW +: LW] = 16'd200;
    expect_grant(4'b0101, w);
    @(posedge clk); #1 ch_req = 4'b0101;
    wait_start(50, n);
    expect_evt(1'b1, w);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (ch_err == '0 && n < 5000);
    vectors++;
    if (n !== 4096) begin
      miscompares++;
      $display("FAIL wd_cycles got %0d exp 4096", n);
    end
    @(posedge clk); #1 ch_req[w] = 1'b0;
    @(negedge clk);
    vectors++;
    if (busy !== 1'b1) begin
      miscompares++;
      $display("FAIL wd_gap got busy=%b exp 1", busy);
    end
    @(posedge clk); #1 gen_done = 1'b1;
    @(negedge clk);
    vectors++;
    if (ch_ack !== '0 || ch_err !== '0) begin
      miscompares++;
      $display("FAIL stray_done got ack=%b err=%b exp 0 0", ch_ack, ch_err);
    end
    @(posedge clk); #1 gen_done = 1'b0;
    expect_grant(ch_req, w);
    wait_start(50, n);
    vectors++;
    if (cur_ch !== 3'd2) begin
      miscompares++;
      $display("FAIL wd_next got %0d exp 2", cur_ch);
    end
    @(posedge clk); #1 gen_done = 1'b1;
    expect_evt(1'b0, w);
    @(posedge clk); #1;
    gen_done = 1'b0; ch_req = '0;
    wait_idle();
  endtask

  task automatic test_simultaneous();
    int n, w;
    expect_grant(4'b0001, w);
    @(posedge clk); #1 ch_req = 4'b0001;
    wait_start(50, n);
    repeat (4095) @(posedge clk);
    @(posedge clk); #1 gen_done = 1'b1;
    expect_evt(1'b0, w);
    @(negedge clk);
    vectors++;
    if (ch_ack !== 4'b0001 || ch_err !== '0) begin
      miscompares++;
      $display("FAIL done_vs_wd got ack=%b err=%b exp 0001 0000",
               ch_ack, ch_err);
    end
    @(posedge clk); #1;
    gen_done = 1'b0; ch_req = '0;
    wait_idle();
  endtask

  task automatic test_drop();
    int n, w;
    ch_len[1*LW +: LW] = 16'd30;
    expect_grant(4'b0010, w);
    @(posedge clk); #1 ch_req = 4'b0010;
    wait_start(50, n);
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      gen_rd = 1'b1;
      ch_data[15:8] = 8'(8'hA0 + i);
      if (i == 3) ch_req = '0;
      @(negedge clk);
      vectors++;
      if (!busy || ch_rd !== 4'b0010 ||
          gen_data !== 8'(8'hA0 + i)) begin
        miscompares++;
        $display("FAIL drop_rd got busy=%b rd=%b data=%h exp 1 0010 %h",
                 busy, ch_rd, gen_data, 8'(8'hA0 + i));
      end
    end
    @(posedge clk); #1;
    gen_rd = 1'b0; gen_done = 1'b1;
    expect_evt(1'b0, w);
    @(posedge clk); #1 gen_done = 1'b0;
    wait_idle();
  endtask

  task automatic test_reset_mid();
    int n, w;
    ch_len[2*LW +: LW]  = 16'd40;
    ch_port[2*16 +: 16] = 16'hBEEF;
    expect_grant(4'b0100, w);
    @(posedge clk); #1 ch_req = 4'b0100;
    wait_start(50, n);
    for (int i = 1; i <= 5; i++) begin
      @(posedge clk); #1 gen_rd = 1'b1;
    end
    rst_n = 1'b0;
    #1;
    vectors++;
    if (busy !== 1'b0 || ch_rd !== '0 || gen_start !== 1'b0 ||
        ch_ack !== '0 || ch_err !== '0) begin
      miscompares++;
      $display("FAIL rst_mid_ctl got busy=%b rd=%b ack=%b err=%b exp 0",
               busy, ch_rd, ch_ack, ch_err);
    end
    vectors++;
    if (gen_len !== '0 || gen_port !== '0 || cur_ch !== 3'd0) begin
      miscompares++;
      $display("FAIL rst_mid_latch got len=%0d port=%h cur=%0d exp 0 0 0",
               gen_len, gen_port, cur_ch);
    end
    gen_rd = 1'b0; ch_req = '0;
    exp_grant.delete();
    exp_evt.delete();
    model_ptr = 0;
    @(posedge clk); #1 rst_n = 1'b1;
    ch_len[1*LW +: LW] = 16'd50;
    ch_len[3*LW +: LW] = 16'd60;
    expect_grant(4'b1010, w);
    @(posedge clk); #1 ch_req = 4'b1010;
    wait_start(50, n);
    vectors++;
    if (cur_ch !== 3'd1) begin
      miscompares++;
      $display("FAIL rst_ptr got %0d exp 1", cur_ch);
    end
    @(posedge clk); #1 gen_done = 1'b1;
    expect_evt(1'b0, w);
    @(posedge clk); #1;
    gen_done = 1'b0; ch_req = '0;
    wait_idle();
  endtask

  initial begin
    test_reset();
    test_single();
    test_fairness();
    test_length();
    test_watchdog();
    test_simultaneous();
    test_drop();
    test_reset_mid();
    repeat (3) @(posedge clk);
    vectors++;
    if (exp_grant.size() != 0 || exp_evt.size() != 0) begin
      miscompares++;
      $display("FAIL leftover got grants=%0d evts=%0d exp 0 0",
               exp_grant.size(), exp_evt.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout got no finish exp finish");
    $fatal(1, "bench timeout");
  end

endmodule

// File: doc/udp_tx_arbiter.md
Name: udp_tx_arbiter

Overview:
- Shares the single UDP/Ethernet frame generator between N_CH payload sources.
- Round-robin arbitration; latches the winner's length and destination port, pulses the generator start, and routes the generator's byte-read strobe and payload data to and from the granted channel.
- Enforces a minimum inter-frame gap and a watchdog on generator completion.
- Sits between the application payload FIFOs and the frame generator.

Parameters:
- N_CH, 4, number of requesting channels (2..8)
- LEN_W, 16, payload length width in bytes
- MAX_LEN, 1472, largest legal UDP payload in bytes
- IFG_CYCLES, 12, idle cycles forced between gen_done and the next gen_start
- TIMEOUT, 4096, cycles allowed from gen_start to gen_done

Ports:
- clk  in  1  single clock
- rst_n  in  1  asynchronous active-low reset
- ch_req  in  N_CH  per-channel request level; held until ch_ack or ch_err
- ch_len  in  N_CH*LEN_W  per-channel payload length, channel i at [i*LEN_W +: LEN_W]
- ch_port  in  N_CH*16  per-channel UDP destination port
- ch_data  in  N_CH*8  per-channel payload byte, valid in the cycle its ch_rd is high
- ch_rd  out  N_CH  per-channel read strobe, one-hot or zero
- ch_ack  out  N_CH  one-cycle pulse when the channel's frame completes
- ch_err  out  N_CH  one-cycle pulse when the request is rejected or times out
- gen_start  out  1  one-cycle start pulse to the generator
- gen_len  out  LEN_W  latched payload length, stable from gen_start until gen_done
- gen_port  out  16  latched destination port, same stability rule as gen_len
- gen_rd  in  1  generator payload-byte request
- gen_data  out  8  ch_data of the granted channel (combinational mux)
- gen_done  in  1  generator frame-complete pulse
- busy  out  1  high in every state except IDLE
- cur_ch  out  3  granted channel index

Behaviour:
- Reset (async, rst_n low): state IDLE, rr_ptr=0, cur_ch=0, gen_len=0, gen_port=0, all pulses 0, busy=0, timers 0.
- States: IDLE, CHECK, START, BUSY, GAP.
- IDLE:
  - If any ch_req is set, pick the first set bit searching from rr_ptr upward with wrap.
  - Latch cur_ch, ch_len and ch_port into gen_len and gen_port, then go to CHECK.
  - Latency from ch_req rising to gen_start is 3 cycles (IDLE → CHECK → START).
- CHECK:
  - If gen_len==0 or gen_len>MAX_LEN: pulse ch_err[cur_ch], set rr_ptr=cur_ch+1 (mod N_CH), go to IDLE.
  - Otherwise go to START.
- START: gen_start=1 for exactly this cycle; clear the watchdog; go to BUSY.
- BUSY:
  - ch_rd[cur_ch]=gen_rd; all other ch_rd bits are 0. gen_data=ch_data[cur_ch].
  - gen_done: pulse ch_ack[cur_ch], set rr_ptr=cur_ch+1, load the gap counter with IFG_CYCLES-1, go to GAP.
  - Watchdog reaches TIMEOUT-1 without gen_done: pulse ch_err[cur_ch], advance rr_ptr, go to GAP. A later stray gen_done is ignored.
  - gen_done and timeout in the same cycle: gen_done wins (ack, no err).
- GAP:
  - Count down and go to IDLE at 0, so there are exactly IFG_CYCLES cycles between the gen_done cycle and the next IDLE.
  - ch_req changes during GAP are ignored.
- Outside BUSY: ch_rd=0, and gen_rd is ignored.
- A channel dropping ch_req after grant does not abort the frame; the frame completes.
- rr_ptr wraps N_CH-1 → 0. The winner becomes lowest priority on the next arbitration, whether the request was acked or erred.
- gen_len and gen_port hold their value until the next grant.
- Reset asserted mid-frame: immediate return to IDLE with no ack or err pulse.

Decomposition:
- Shared package holds:
  - state encoding constants (IDLE=0, CHECK=1, START=2, BUSY=3, GAP=4)
  - UDP_MAX_PAYLOAD=1472
  - ETH_IFG_BYTES=12
- Sub-module rr_pick: combinational round-robin priority encoder. Inputs req[N_CH] and ptr; outputs idx and found. It is reusable by other arbiters in the design.

Test Plan:
- Single request: ch_req=0001, len=18, port=0xC360 → gen_start 3 cycles later with gen_len=18 and gen_port=0xC360. Model gen_rd for 18 cycles: ch_rd[0] mirrors gen_rd 18 times. gen_done → ch_ack[0] pulse, busy low after 12 gap cycles.
- Fairness: all four requests held constant, immediate gen_done model → grant order 0,1,2,3,0,1. No ch_rd strobe ever reaches a non-granted channel.
- Length checks: ch_len[2]=0 → ch_err[2] pulse, no gen_start. ch_len[1]=1473 → ch_err[1]. ch_len[3]=1472 → accepted.
- Watchdog: gen_done never asserted → ch_err at exactly 4096 cycles after gen_start, GAP entered, then the next requester is granted. A stray gen_done is then ignored.
- Simultaneous events: gen_done in the same cycle as the timeout → ack only. ch_req dropped mid-BUSY → frame completes and ack is still pulsed.
- Reset mid-BUSY: assert rst_n low at byte 5 → all outputs at reset values in the same cycle, rr_ptr=0. A request after release is granted cleanly.
